parity_tx_seq: RTL

PARITY_TX_SEQ -- requirements
Module: parity_tx_seq

---
 rtl/parity_tx_seq_pkg.sv | 24 ++
 rtl/parity_tx_seq_if.sv | 42 ++++
 rtl/parity_bit_acc.sv | 28 ++
 rtl/parity_tx_seq.sv | 118 +++++++++++
 4 files changed

// File: rtl/parity_tx_seq_pkg.sv
// Shared state encoding, default sizes and parity helpers for the
// parity_tx_seq serializer.
package parity_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_e;

  // Running even parity: fold one more bit into the accumulator.
  function automatic logic par_step(input logic acc, input logic b);
    return acc ^ b;
  endfunction

  // Final parity bit sent on the wire; odd parity is the inverted even parity.
  function automatic logic par_final(input logic acc, input logic odd);
    return acc ^ odd;
  endfunction

endpackage

// File: rtl/parity_tx_seq_if.sv
// Parallel-in / serial-out handshake bundle for parity_tx_seq.
// The master side drives words and consumes beats; the slave side is the serializer.
interface parity_tx_seq_if import parity_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              ser_valid;
  logic              ser_data;
  logic              ser_last;
  logic              ser_ready;
  logic              done;
  logic [CNT_W-1:0]  frame_cnt;

  modport master (
    output in_valid,
    output in_data,
    output ser_ready,
    input  in_ready,
    input  ser_valid,
    input  ser_data,
    input  ser_last,
    input  done,
    input  frame_cnt
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  ser_ready,
    output in_ready,
    output ser_valid,
    output ser_data,
    output ser_last,
    output done,
    output frame_cnt
  );

endinterface

// File: rtl/parity_bit_acc.sv
// One-bit parity accumulator: clear wins over enable, otherwise the value holds.
module parity_bit_acc import parity_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  input  logic i_bit,
  output logic o_acc
);

  logic r_acc;

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= 1'b0;
    end else if (i_clear) begin
      r_acc <= 1'b0;
    end else if (i_enable) begin
      r_acc <= par_step(r_acc, i_bit);
    end else begin
      r_acc <= r_acc;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/parity_tx_seq.sv
// Serializes a DATA_W word MSB-first followed by a parity beat, counting frames.
// Define PARITY_TX_ODD_EN to send odd parity instead of even parity.
module parity_tx_seq import parity_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  parity_tx_seq_if.slave   bus
);

  localparam int              BC_W     = $clog2(DATA_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

`ifdef PARITY_TX_ODD_EN
  localparam logic ODD_PAR = 1'b1;
`else
  localparam logic ODD_PAR = 1'b0;
`endif

  state_e            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [BC_W-1:0]   r_bit_cnt;
  logic              r_in_ready;
  logic              r_ser_valid;
  logic              r_ser_data;
  logic              r_ser_last;
  logic              r_done;
  logic [CNT_W-1:0]  r_frame_cnt;

  logic w_take;
  logic w_beat;
  logic w_acc;
  logic w_cur_bit;

  assign w_take    = r_in_ready & bus.in_valid;
  assign w_beat    = (r_state == DATA) & bus.ser_ready;
  assign w_cur_bit = r_shift[DATA_W-1];

  parity_bit_acc u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_take),
    .i_enable (w_beat),
    .i_bit    (w_cur_bit),
    .o_acc    (w_acc)
  );

  // Frame sequencer with registered handshake and serial outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shift     <= {DATA_W{1'b0}};
      r_bit_cnt   <= {BC_W{1'b0}};
      r_in_ready  <= 1'b1;
      r_ser_valid <= 1'b0;
      r_ser_data  <= 1'b0;
      r_ser_last  <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= {CNT_W{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_state     <= DATA;
            r_shift     <= bus.in_data;
            r_bit_cnt   <= {BC_W{1'b0}};
            r_in_ready  <= 1'b0;
            r_ser_valid <= 1'b1;
            r_ser_data  <= bus.in_data[DATA_W-1];
            r_ser_last  <= 1'b0;
          end
        end
        DATA: begin
          if (bus.ser_ready) begin
            r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + BC_W'(1);
            if (r_bit_cnt == LAST_BIT) begin
              // The accumulator only sees this last bit next cycle, so fold it in here.
              r_state    <= PAR;
              r_ser_data <= par_final(par_step(w_acc, w_cur_bit), ODD_PAR);
              r_ser_last <= 1'b1;
            end else begin
              r_ser_data <= r_shift[DATA_W-2];
            end
          end
        end
        PAR: begin
          if (bus.ser_ready) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_ser_valid <= 1'b0;
            r_ser_data  <= 1'b0;
            r_ser_last  <= 1'b0;
            r_done      <= 1'b1;
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_ser_valid <= 1'b0;
          r_ser_data  <= 1'b0;
          r_ser_last  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.ser_valid = r_ser_valid;
  assign bus.ser_data  = r_ser_data;
  assign bus.ser_last  = r_ser_last;
  assign bus.done      = r_done;
  assign bus.frame_cnt = r_frame_cnt;

endmodule
